fcmp_pipe: RTL

Pipelined floating-point compare execution unit for the FPU issue path.
- Accepts single-precision operand pairs plus an opcode and destination tag from the dispatch stage under a valid/ready handshake.
- Evaluates feq/flt/fle over a 2-stage pipeline.
- Hands a 32-bit integer result (0 or 1) and the tag to writeback under a second valid/ready handshake.
- Pure comparison logic matches the team's existing less-than unit bit for bit.

---
 rtl/fcmp_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: 2-stage single-precision feq/flt/fle unit with valid/ready on both sides.
// Optional FCMP_ZERO_EQ_EN makes +0 and -0 compare equal.
module fcmp_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag
);
    logic             w_s2_adv, w_s1_adv, w_acc;
    logic [8:0]       w_esub;
    logic [24:0]      w_msub;
    logic             w_lt, w_eq, w_res;

    logic             r_s1_valid;
    logic [1:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_sx, r_s1_sy, r_s1_eeq, r_s1_elt, r_s1_meq, r_s1_mlt, r_s1_xeq;
`ifdef FCMP_ZERO_EQ_EN
    logic             r_s1_zz;
`endif

    logic             r_s2_valid;
    logic             r_s2_res;
    logic [TAG_W-1:0] r_s2_tag;

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv & ~flush & ~rst;
    assign w_acc    = in_valid & in_ready;

    // Magnitude ordering comes from subtract borrows, one bit wider than the field.
    assign w_esub = {1'b0, in_x[30:23]} - {1'b0, in_y[30:23]};
    assign w_msub = {2'b0, in_x[22:0]} - {2'b0, in_y[22:0]};

    always_ff @(posedge clk) begin
        if (rst || flush)
            r_s1_valid <= 1'b0;
        else if (w_acc)
            r_s1_valid <= 1'b1;
        else if (w_s1_adv)
            r_s1_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_s1_op  <= in_op;
            r_s1_tag <= in_tag;
            r_s1_sx  <= in_x[31];
            r_s1_sy  <= in_y[31];
            r_s1_eeq <= (in_x[30:23] == in_y[30:23]);
            r_s1_elt <= w_esub[8];
            r_s1_meq <= (in_x[22:0] == in_y[22:0]);
            r_s1_mlt <= w_msub[24];
            r_s1_xeq <= (in_x == in_y);
`ifdef FCMP_ZERO_EQ_EN
            r_s1_zz  <= (in_x[30:0] == 31'd0) && (in_y[30:0] == 31'd0);
`endif
        end
    end

    always_comb begin
        w_lt = 1'b0;
        if (r_s1_sx & ~r_s1_sy)
            w_lt = 1'b1;
        else if (~r_s1_sx & r_s1_sy)
            w_lt = 1'b0;
        else if (r_s1_sx)
            w_lt = r_s1_eeq ? (~r_s1_mlt & ~r_s1_meq) : (~r_s1_elt & ~r_s1_eeq);
        else
            w_lt = r_s1_eeq ? r_s1_mlt : r_s1_elt;
`ifdef FCMP_ZERO_EQ_EN
        w_eq = r_s1_xeq | r_s1_zz;
        if (r_s1_zz)
            w_lt = 1'b0;
`else
        w_eq = r_s1_xeq;
`endif
        case (r_s1_op)
            2'b00:   w_res = w_eq;
            2'b01:   w_res = w_lt;
            2'b10:   w_res = w_lt | w_eq;
            default: w_res = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= 1'b0;
            r_s2_tag   <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res <= w_res;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_res   = {31'b0, r_s2_res};
    assign out_tag   = r_s2_tag;
endmodule
